// File: rtl/gf_sbox_arb_if.sv
// gf_sbox_arb_if: word request/response handshakes and the shared S-box lane
// connection for gf_sbox_arb.
interface gf_sbox_arb_if;
    logic        rq0_valid;
    logic        rq0_ready;
    logic [31:0] rq0_data;
    logic        rq0_inv;
    logic        rq1_valid;
    logic        rq1_ready;
    logic [31:0] rq1_data;
    logic        rq1_inv;
    logic        rs0_valid;
    logic        rs1_valid;
    logic [31:0] rs_data;
    logic        sb_vld;
    logic [7:0]  sb_x;
    logic        sb_inv;
    logic [7:0]  sb_y;

    modport slave (
        input  rq0_valid, rq0_data, rq0_inv, rq1_valid, rq1_data, rq1_inv, sb_y,
        output rq0_ready, rq1_ready, rs0_valid, rs1_valid, rs_data, sb_vld, sb_x, sb_inv
    );

    modport master (
        output rq0_valid, rq0_data, rq0_inv, rq1_valid, rq1_data, rq1_inv, sb_y,
        input  rq0_ready, rq1_ready, rs0_valid, rs1_valid, rs_data, sb_vld, sb_x, sb_inv
    );
endinterface

// File: rtl/gf_sbox_arb.sv
// gf_sbox_arb: round-robin arbiter that serialises two 32-bit word requests onto
// one shared byte-wide S-box lane and reassembles the substituted word.
module gf_sbox_arb #(
    parameter int SBOX_LAT = 1
) (
    input logic          clk,
    input logic          rst_n,
    gf_sbox_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t      state_q, state_d;
    logic        rr_q, rr_d;
    logic        inv_q, inv_d;
    logic        port_q, port_d;
    logic [1:0]  k_q, k_d;
    logic [1:0]  dcnt_q, dcnt_d;
    logic [31:0] word_q, word_d;
    logic [31:0] res_q, res_d;
    logic [31:0] rs_data_q, rs_data_d;
    logic        gnt0, gnt1, acc;
    logic [2:0]  tag_cur, tag_cap;

    // rr_q remembers the port served last; a tie goes to the other one
    assign gnt0 = bus.rq0_valid && (!bus.rq1_valid || rr_q);
    assign gnt1 = bus.rq1_valid && !gnt0;
    assign acc  = state_q == IDLE && (gnt0 || gnt1);

    assign bus.rq0_ready = rst_n && state_q == IDLE && gnt0;
    assign bus.rq1_ready = rst_n && state_q == IDLE && gnt1;
    assign bus.sb_vld    = state_q == ISSUE;
    assign bus.sb_x      = word_q[{k_q, 3'b000} +: 8];
    assign bus.sb_inv    = inv_q;
    assign bus.rs0_valid = state_q == DONE && !port_q;
    assign bus.rs1_valid = state_q == DONE && port_q;
    assign bus.rs_data   = rs_data_q;
    assign tag_cur       = {bus.sb_vld, k_q};

    // Capture is steered by the issue tag delayed to match the lane latency
    generate
        if (SBOX_LAT == 0) begin : g_nolat
            assign tag_cap = tag_cur;
        end else begin : g_lat
            logic [2:0] tag_q [SBOX_LAT];
            logic [2:0] tag_d [SBOX_LAT];
            always_comb begin
                tag_d[0] = tag_cur;
                for (int i = 1; i < SBOX_LAT; i++) tag_d[i] = tag_q[i-1];
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < SBOX_LAT; i++) tag_q[i] <= '0;
                end else begin
                    tag_q <= tag_d;
                end
            end
            assign tag_cap = tag_q[SBOX_LAT-1];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        inv_d   = inv_q;
        port_d  = port_q;
        word_d  = word_q;
        k_d     = k_q;
        dcnt_d  = dcnt_q;
        res_d   = res_q;
        if (tag_cap[2]) res_d[{tag_cap[1:0], 3'b000} +: 8] = bus.sb_y;
        case (state_q)
            IDLE: if (acc) begin
                state_d = ISSUE;
                rr_d    = gnt1;
                port_d  = gnt1;
                inv_d   = gnt1 ? bus.rq1_inv : bus.rq0_inv;
                word_d  = gnt1 ? bus.rq1_data : bus.rq0_data;
                k_d     = 2'd0;
            end
            ISSUE: if (k_q == 2'd3) begin
                if (SBOX_LAT > 0) state_d = DRAIN;
                else state_d = DONE;
                dcnt_d = 2'd0;
            end else begin
                k_d = k_q + 2'd1;
            end
            DRAIN: if (dcnt_q == 2'(SBOX_LAT - 1)) state_d = DONE;
                   else dcnt_d = dcnt_q + 2'd1;
            default: state_d = IDLE;
        endcase
        rs_data_d = (state_d == DONE) ? res_d : rs_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_q      <= 1'b1;
            inv_q     <= 1'b0;
            port_q    <= 1'b0;
            k_q       <= 2'd0;
            dcnt_q    <= 2'd0;
            word_q    <= '0;
            res_q     <= '0;
            rs_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            inv_q     <= inv_d;
            port_q    <= port_d;
            k_q       <= k_d;
            dcnt_q    <= dcnt_d;
            word_q    <= word_d;
            res_q     <= res_d;
            rs_data_q <= rs_data_d;
        end
    end
endmodule

// File: tb/tb_gf_sbox_arb.sv
// tb_gf_sbox_arb: three gf_sbox_arb instances (SBOX_LAT 0/1/2) share one stimulus,
// each fed by a latency-matched arithmetic AES S-box lane model.
module tb_gf_sbox_arb;
    logic        clk = 0, rst_n = 0;
    logic        v0 = 0, v1 = 0, i0 = 0, i1 = 0;
    logic [31:0] d0 = 0, d1 = 0;
    logic        rdy0 [3], rdy1 [3], rsv0 [3], rsv1 [3], sbv [3], sbi [3];
    logic [31:0] rsd [3];
    logic [7:0]  sbx [3];
    int          tests = 0, fails = 0;
    bit          last = 1;

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        for (int x = 1; x < 256; x++) if (gmul(a, 8'(x)) == 8'h01) return 8'(x);
        return 8'h00;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] x, input logic inv);
        logic [7:0] t;
        if (inv) return ginv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
        t = ginv(x);
        return t ^ rotl(t, 1) ^ rotl(t, 2) ^ rotl(t, 3) ^ rotl(t, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] word_ref(input logic [31:0] w, input logic inv);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = sbox_ref(w[8*b +: 8], inv);
        return r;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : lane
        gf_sbox_arb_if bus ();
        logic [7:0] y0;
        gf_sbox_arb #(.SBOX_LAT(g)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
        assign bus.rq0_valid = v0;
        assign bus.rq0_data  = d0;
        assign bus.rq0_inv   = i0;
        assign bus.rq1_valid = v1;
        assign bus.rq1_data  = d1;
        assign bus.rq1_inv   = i1;
        assign rdy0[g] = bus.rq0_ready;
        assign rdy1[g] = bus.rq1_ready;
        assign rsv0[g] = bus.rs0_valid;
        assign rsv1[g] = bus.rs1_valid;
        assign rsd[g]  = bus.rs_data;
        assign sbv[g]  = bus.sb_vld;
        assign sbx[g]  = bus.sb_x;
        assign sbi[g]  = bus.sb_inv;
        assign y0 = sbox_ref(bus.sb_x, bus.sb_inv);
        if (g == 0) begin : g_comb
            assign bus.sb_y = y0;
        end else begin : g_pipe
            logic [7:0] p [g];
            always @(posedge clk) begin
                p[0] <= y0;
                for (int i = 1; i < g; i++) p[i] <= p[i-1];
            end
            assign bus.sb_y = p[g-1];
        end
    end

    task automatic apply_reset();
        v0 = 0; v1 = 0; rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1; last = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        v0 = 1; v1 = 1;
        #1;
        for (int g = 0; g < 3; g++) begin
            tests++;
            if ({rdy0[g], rdy1[g], rsv0[g], rsv1[g], sbv[g], sbi[g], sbx[g], rsd[g]} !== 46'd0) begin
                fails++;
                $display("FAIL reset_outputs lane%0d got rdy=%b%b rsv=%b%b sbv=%b sbi=%b sbx=%h rsd=%h required all zero",
                         g, rdy0[g], rdy1[g], rsv0[g], rsv1[g], sbv[g], sbi[g], sbx[g], rsd[g]);
            end
        end
        v0 = 0; v1 = 0;
    endtask

    // One word through all three lanes; tie raises the other valid in the accept cycle
    task automatic test_word(input bit port, input logic [31:0] data, input bit inv,
                             input logic [31:0] exp, input bit tie);
        int hits [3];
        int kk;
        hits = '{0, 0, 0};
        if (port) begin v1 = 1; d1 = data; i1 = inv; v0 = tie; d0 = $urandom; end
        else begin v0 = 1; d0 = data; i0 = inv; v1 = tie; d1 = $urandom; end
        #1;
        for (int g = 0; g < 3; g++) begin
            tests++;
            if ({rdy0[g], rdy1[g]} !== (port ? 2'b01 : 2'b10)) begin
                fails++;
                $display("FAIL grant lane%0d got ready=%b%b required port %0d (tie=%0d)", g, rdy0[g], rdy1[g], port, tie);
            end
        end
        @(negedge clk);
        v0 = 0; v1 = 0;
        for (int c = 1; c <= 9; c++) begin
            kk = (c <= 4) ? c - 1 : 3;
            for (int g = 0; g < 3; g++) begin
                tests++;
                if ({sbv[g], sbx[g], sbi[g]} !== {c <= 4, data[8*kk +: 8], inv}) begin
                    fails++;
                    $display("FAIL issue lane%0d A+%0d got vld=%b x=%h inv=%b required vld=%b x=%h inv=%b",
                             g, c, sbv[g], sbx[g], sbi[g], c <= 4, data[8*kk +: 8], inv);
                end
                if (rsv0[g] || rsv1[g]) begin
                    hits[g]++;
                    tests++;
                    if (rsv0[g] !== !port || rsv1[g] !== port || c != 5 + g || rsd[g] !== exp) begin
                        fails++;
                        $display("FAIL result lane%0d got A+%0d rsv=%b%b data=%h required A+%0d port %0d data=%h",
                                 g, c, rsv0[g], rsv1[g], rsd[g], 5 + g, port, exp);
                    end
                end
            end
            @(negedge clk);
        end
        for (int g = 0; g < 3; g++) begin
            tests++;
            if (hits[g] != 1 || rsd[g] !== exp) begin
                fails++;
                $display("FAIL pulse_hold lane%0d got pulses=%0d rsd=%h required 1 pulse rsd=%h", g, hits[g], rsd[g], exp);
            end
        end
        last = port;
    endtask

    task automatic test_contention();
        logic [32:0] q [$];
        logic [32:0] e;
        int nres = 0, last_acc = -1;
        bit exp_port = 0, ref0 = 0, ref1 = 0, p;
        apply_reset();
        d0 = $urandom; i0 = 1'($urandom); d1 = $urandom; i1 = 1'($urandom);
        v0 = 1; v1 = 1;
        for (int c = 0; c < 120 && nres < 8; c++) begin
            if (ref0) begin d0 = $urandom; i0 = 1'($urandom); ref0 = 0; end
            if (ref1) begin d1 = $urandom; i1 = 1'($urandom); ref1 = 0; end
            #1;
            if (rsv0[1] || rsv1[1]) begin
                nres++;
                tests++;
                e = (q.size() != 0) ? q.pop_front() : 33'h1_dead_beef;
                if ({rsv1[1], rsd[1]} !== e || rsv0[1] === rsv1[1]) begin
                    fails++;
                    $display("FAIL contention_result #%0d got port=%b data=%h required port=%b data=%h",
                             nres, rsv1[1], rsd[1], e[32], e[31:0]);
                end
            end
            if (rdy0[1] || rdy1[1]) begin
                p = rdy1[1];
                tests++;
                if (p !== exp_port || (rdy0[1] && rdy1[1]) || (last_acc >= 0 && c - last_acc != 7)) begin
                    fails++;
                    $display("FAIL contention_grant cycle %0d got ready=%b%b gap=%0d required port %0d gap 7",
                             c, rdy0[1], rdy1[1], c - last_acc, exp_port);
                end
                q.push_back({p, p ? word_ref(d1, i1) : word_ref(d0, i0)});
                last_acc = c;
                exp_port = !exp_port;
                if (p) ref1 = 1; else ref0 = 1;
            end
            @(negedge clk);
        end
        tests++;
        if (nres != 8) begin
            fails++;
            $display("FAIL contention_timeout got %0d results required 8", nres);
        end
        v0 = 0; v1 = 0;
    endtask

    task automatic test_reset_midop();
        apply_reset();
        v0 = 1; d0 = 32'h01FF5300; i0 = 0;
        @(negedge clk);
        v0 = 0;
        repeat (2) @(negedge clk);
        rst_n = 0;
        for (int r = 0; r < 2; r++) begin
            #1;
            for (int g = 0; g < 3; g++) begin
                tests++;
                if ({rdy0[g], rdy1[g], rsv0[g], rsv1[g], sbv[g], sbi[g], sbx[g], rsd[g]} !== 46'd0) begin
                    fails++;
                    $display("FAIL midop_reset lane%0d got rsv=%b%b sbv=%b sbx=%h rsd=%h required all zero",
                             g, rsv0[g], rsv1[g], sbv[g], sbx[g], rsd[g]);
                end
            end
            @(negedge clk);
        end
        rst_n = 1; last = 1;
        for (int c = 0; c < 10; c++) begin
            for (int g = 0; g < 3; g++) begin
                tests++;
                if (rsv0[g] || rsv1[g]) begin
                    fails++;
                    $display("FAIL stale_pulse lane%0d cycle %0d got rsv=%b%b required 00", g, c, rsv0[g], rsv1[g]);
                end
            end
            @(negedge clk);
        end
        test_word(0, 32'h01FF5300, 0, 32'h7C16ED63, 1);
    endtask

    task automatic test_data_change();
        apply_reset();
        v0 = 1; d0 = 32'h01FF5300; i0 = 0;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            if (c == 2) d0 = 32'hFFFFFFFF;
            #1;
            tests++;
            if (rdy0[1] !== (c == 7) || rdy1[1] !== 1'b0 || rsv0[1] !== (c == 6 || c == 13) || rsv1[1] !== 1'b0) begin
                fails++;
                $display("FAIL data_change_ctrl A+%0d got rdy=%b%b rsv=%b%b required rdy0=%b rsv0=%b",
                         c, rdy0[1], rdy1[1], rsv0[1], rsv1[1], c == 7, c == 6 || c == 13);
            end
            if (c == 6 || c == 13) begin
                tests++;
                if (rsd[1] !== (c == 6 ? 32'h7C16ED63 : 32'h16161616)) begin
                    fails++;
                    $display("FAIL data_change_word A+%0d got %h required %h",
                             c, rsd[1], c == 6 ? 32'h7C16ED63 : 32'h16161616);
                end
            end
            if (c == 8) v0 = 0;
        end
        v0 = 0;
    endtask

    task automatic test_random();
        bit p, iv;
        logic [31:0] w;
        apply_reset();
        repeat (8) begin
            p = 1'($urandom); iv = 1'($urandom); w = $urandom;
            test_word(p, w, iv, word_ref(w, iv), p != last ? 1'($urandom) : 1'b0);
        end
    endtask

    initial begin
        test_reset();
        apply_reset();
        test_word(0, 32'h01FF5300, 0, 32'h7C16ED63, 0);
        test_word(1, 32'h0000ED63, 1, 32'h52525300, 0);
        test_contention();
        test_reset_midop();
        test_data_change();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish within 100000 time units");
        $fatal(1);
    end
endmodule

// File: doc/gf_sbox_arb.md
Name: gf_sbox_arb

Overview:
- Sequences and shares one byte-wide composite-field AES S-box lane (built from GF(2^2)/GF(2^4) arithmetic) between two 32-bit word requesters.
- Port 0 is key expansion (SubWord); port 1 is the round datapath (SubBytes column).
- Arbitrates round-robin on whole words and serialises each word into four byte issues, LSB first.
- Collects the S-box results through a parameterised pipeline latency and returns the substituted word.

Parameters:
- SBOX_LAT, 1, register stages inside the shared S-box lane. Legal values are 0, 1 and 2; sb_y for the byte issued in cycle c is valid in cycle c+SBOX_LAT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rq0_valid  in  1  port 0 word request.
- rq0_ready  out  1  port 0 request accepted when high with rq0_valid.
- rq0_data  in  32  port 0 word to substitute.
- rq0_inv  in  1  port 0 select: 0 = forward S-box, 1 = inverse S-box.
- rq1_valid  in  1  port 1 word request.
- rq1_ready  out  1  port 1 accept.
- rq1_data  in  32  port 1 word.
- rq1_inv  in  1  port 1 forward/inverse select.
- rs0_valid  out  1  one-cycle pulse: result for port 0 on rs_data.
- rs1_valid  out  1  one-cycle pulse: result for port 1 on rs_data.
- rs_data  out  32  substituted word, shared by both ports.
- sb_vld  out  1  byte issue strobe to the S-box lane.
- sb_x  out  8  byte to the S-box lane.
- sb_inv  out  1  direction select to the S-box lane.
- sb_y  in  8  S-box lane result.

Behaviour:
- Reset (async assert, sync release): FSM = IDLE, RR pointer = 1 (port 0 wins the first tie). All outputs are 0: rq*_ready, rs*_valid, rs_data, sb_vld, sb_x, sb_inv.
- FSM states are IDLE, ISSUE, DRAIN and DONE.
- IDLE:
  - rqN_ready is high only for the granted port; the other ready is low. Ready does not depend on valid beyond grant selection.
  - If only one valid is high, that port is granted.
  - If both are high, the grant goes to the port not served last; the RR pointer updates on acceptance.
  - On acceptance (cycle A), latch the word, the inv bit and the port id, set byte index k = 0, and go to ISSUE.
- ISSUE, cycles A+1 to A+4:
  - sb_vld = 1, sb_x = word[8k+7:8k], sb_inv = latched inv, and k increments each cycle.
  - After k = 3, go to DRAIN if SBOX_LAT > 0, otherwise go to DONE.
- Capture: sb_y is written into result byte k in cycle A+1+k+SBOX_LAT. Capture uses a SBOX_LAT-deep delay line of the (sb_vld, k) tag, not the FSM state.
- DRAIN: lasts SBOX_LAT cycles, with sb_vld = 0 and sb_x/sb_inv held at their last values. Then go to DONE.
- DONE, cycle A+5+SBOX_LAT:
  - rs_data takes the assembled word; the matching rsN_valid is 1 for exactly this cycle.
  - Next state is IDLE, and both readies are low during DONE.
  - Throughput is one word per 6+SBOX_LAT cycles.
- rs_data holds its value until the next DONE. rs*_valid has no backpressure; requesters must sink it.
- Requests are ignored while not in IDLE. rq*_data changing after acceptance has no effect.
- A requester holding valid with no handshake is still served later. Under continuous contention the grants strictly alternate, so there is no starvation.
- rq*_inv is sampled only at acceptance and is constant for all four bytes of a word.
- Reset mid-operation aborts the word with no rs pulse. Pipeline tags are cleared so no stale capture occurs after release.
- sb_x and sb_inv hold their last values when sb_vld = 0, to avoid toggle power.

Test Plan:
- Port 0 alone, SBOX_LAT = 1, rq0_data = 0x01FF5300, inv = 0.
  - sb_x sequence is 00, 53, FF, 01 in cycles A+1 to A+4.
  - rs0_valid pulses at A+6 with rs_data = 0x7C16ED63; rs1_valid stays 0.
- Port 1 alone, inv = 1, rq1_data = 0x0000ED63.
  - sb_inv = 1 on all issues.
  - rs_data = 0x52525300 (InvS(00) = 52), with rs1_valid pulse only.
- Both ports valid continuously from reset.
  - Grants go 0, 1, 0, 1, and each accept is 6+SBOX_LAT cycles apart.
  - Each result matches its own port's word and direction.
- Sweep SBOX_LAT = 0, 1, 2 with bench S-box model delayed accordingly.
  - rs pulse appears at A+5, A+6 and A+7 respectively, with identical data 0x7C16ED63.
- Assert rst_n low in cycle A+3, then release.
  - No rs pulse occurs, and all outputs read 0 during reset.
  - The next request from port 0 completes correctly and is granted before port 1 on a tie.
- rq0_data changed to 0xFFFFFFFF at A+2 with valid still high.
  - The in-flight result is unaffected (0x7C16ED63).
  - The second word 0xFFFFFFFF is accepted only after DONE and returns 0x16161616.
